// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU
//
// Purpose: radix-2 sign-magnitude multiplier. Operands are converted to
// magnitudes on acceptance, multiplied unsigned over WIDTH cycles, then the
// 2*WIDTH-bit product is negated if exactly one operand was negative.
//
// Ports:
//   clk     in   1      system clock, rising edge
//   reset   in   1      synchronous, active-high reset
//   start   in   1      request, sampled only in IDLE
//   kill    in   1      pipeline flush, aborts any operation
//   op      in   2      00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   a       in   WIDTH  rs1 operand
//   b       in   WIDTH  rs2 operand
//   busy    out  1      high in CALC, FIX and DONE
//   done    out  1      one-cycle completion pulse
//   result  out  WIDTH  product word, held between completions

module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             kill,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_count;
    logic                 r_neg;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_result;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_fixed;
    logic                 w_last;
    logic                 w_accept;

    // a is signed for MULH and MULHSU, b only for MULH.
    assign w_a_neg  = ((op == 2'b01) || (op == 2'b10)) && a[WIDTH-1];
    assign w_b_neg  = (op == 2'b01) && b[WIDTH-1];
    // The magnitude of the most-negative value is itself, which is correct
    // when read as unsigned.
    assign w_a_mag  = w_a_neg ? (~a + WIDTH'(1)) : a;
    assign w_b_mag  = w_b_neg ? (~b + WIDTH'(1)) : b;
    assign w_accept = start && !kill;

    // Carry out of the upper-half add becomes the top bit after the shift.
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_fixed = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
    assign w_last  = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_CALC;
            S_CALC: begin
                if (kill)        w_next = S_IDLE;
                else if (w_last) w_next = S_FIX;
            end
            S_FIX:  w_next = kill ? S_IDLE : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_op     <= 2'b00;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= w_a_mag;
                        r_mplier <= w_b_mag;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_op     <= op;
                    end
                end
                S_CALC: begin
                    if (!kill) begin
                        // Partial sums never reach below bit 0 of r_acc, so
                        // after WIDTH steps r_acc holds the full product.
                        r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + CW'(1);
                    end
                end
                S_FIX: begin
                    // Result is loaded here so it is valid during DONE; a kill
                    // in FIX leaves the previous result untouched.
                    if (!kill) begin
                        r_acc    <= w_fixed;
                        r_result <= (r_op == 2'b00) ? w_fixed[WIDTH-1:0]
                                                    : w_fixed[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - Self-checking testbench for mul_seq

module tb_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_q[$];
    logic [31:0] last_result;

    mul_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex;
        logic [63:0] ey;
        logic [63:0] p;
        ex = ((o == 2'b01) || (o == 2'b10)) ? {{32{x[31]}}, x} : {32'b0, x};
        ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
        p  = ex * ey;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Entered on a negedge (cycle 0); leaves on the negedge of cycle 35.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] expv, input string name);
        logic eb;
        logic ed;
        logic [31:0] e;
        start = 1'b1; op = o; a = x; b = y;
        exp_q.push_back(expv);
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            eb = (c >= 1) && (c <= 34);
            ed = (c == 34);
            n_vec++;
            if (busy !== eb) begin
                n_err++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, c, busy, eb);
            end
            n_vec++;
            if (done !== ed) begin
                n_err++;
                $display("FAIL %s done cycle %0d: got %b expected %b", name, c, done, ed);
            end
            if (done === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (result !== e) begin
                    n_err++;
                    $display("FAIL %s result: got %h expected %h", name, result, e);
                end
                last_result = e;
            end
            if (c == 1) begin
                // Operands changed after acceptance must not matter.
                start = 1'b0; op = ~o; a = ~x; b = y ^ 32'h5a5a_5a5a;
            end
        end
        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: got no done, expected result %h", name, exp_q[0]);
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b expected 0", done); end
        n_vec++;
        if (result !== 32'h0) begin n_err++; $display("FAIL reset result: got %h expected 0", result); end
        reset = 1'b0;
        last_result = 32'h0;
    endtask

    task automatic test_basic;
        run_op(2'b00, 32'd7, 32'd6, 32'h0000_002A, "mul_7x6");
    endtask

    task automatic test_highs;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1");
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_minsq");
    endtask

    task automatic test_edges;
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mul_min_m1");
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_min_m1");
        run_op(2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, "mul_zero");
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 6; i++) begin
            o = 2'(i % 4);
            x = $urandom;
            y = $urandom;
            run_op(o, x, y, model(o, x, y), "random");
        end
    endtask

    task automatic test_back_to_back;
        logic eb;
        logic ed;
        logic [31:0] e;
        start = 1'b1; op = 2'b00; a = 32'd1234; b = 32'd5678;
        exp_q.push_back(32'd7006652);
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            eb = ((c >= 1) && (c <= 34)) || ((c >= 36) && (c <= 69));
            ed = (c == 34) || (c == 69);
            n_vec++;
            if (busy !== eb) begin
                n_err++;
                $display("FAIL b2b busy cycle %0d: got %b expected %b", c, busy, eb);
            end
            n_vec++;
            if (done !== ed) begin
                n_err++;
                $display("FAIL b2b done cycle %0d: got %b expected %b", c, done, ed);
            end
            if (done === 1'b1 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (result !== e) begin
                    n_err++;
                    $display("FAIL b2b result cycle %0d: got %h expected %h", c, result, e);
                end
                last_result = e;
            end
            case (c)
                1:  start = 1'b0;
                5:  begin start = 1'b1; op = 2'b11; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
                6:  start = 1'b0;
                34: begin start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3; end
                35: begin start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd11; exp_q.push_back(32'd99); end
                36: start = 1'b0;
                default: ;
            endcase
        end
        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL b2b timeout: got %0d outstanding results, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_kill;
        logic [31:0] prev;
        logic eb;
        prev = last_result;
        start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd100;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            eb = (c <= 10);
            n_vec++;
            if (busy !== eb) begin
                n_err++;
                $display("FAIL kill busy cycle %0d: got %b expected %b", c, busy, eb);
            end
            n_vec++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL kill done cycle %0d: got %b expected 0", c, done);
            end
            if (c == 1)  start = 1'b0;
            if (c == 10) kill = 1'b1;
            if (c == 11) kill = 1'b0;
        end
        n_vec++;
        if (result !== prev) begin
            n_err++;
            $display("FAIL kill result held: got %h expected %h", result, prev);
        end
        start = 1'b1; kill = 1'b1; op = 2'b11; a = 32'd5; b = 32'd5;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0; kill = 1'b0;
            n_vec++;
            if (busy !== 1'b0) begin
                n_err++;
                $display("FAIL kill_start busy cycle %0d: got %b expected 0", c, busy);
            end
        end
    endtask

    task automatic test_reset_midop;
        start = 1'b1; op = 2'b01; a = 32'h1234_5678; b = 32'h8765_4321;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == 1)  start = 1'b0;
            if (c == 20) reset = 1'b1;
            if (c == 21) begin
                n_vec++;
                if (busy !== 1'b0) begin n_err++; $display("FAIL midreset busy: got %b expected 0", busy); end
                n_vec++;
                if (done !== 1'b0) begin n_err++; $display("FAIL midreset done: got %b expected 0", done); end
                n_vec++;
                if (result !== 32'h0) begin n_err++; $display("FAIL midreset result: got %h expected 0", result); end
                reset = 1'b0;
                last_result = 32'h0;
            end
        end
        run_op(2'b00, 32'd3, 32'd5, 32'd15, "mul_3x5_after_reset");
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; start = 1'b0; kill = 1'b0;
        op = 2'b00; a = 32'h0; b = 32'h0;
        n_vec = 0; n_err = 0; last_result = 32'h0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_highs;
        test_edges;
        test_random;
        test_back_to_back;
        test_kill;
        test_reset_midop;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
